// File: rtl/ads868x_scan_ctrl.sv
// Purpose: scans the enabled analog mux inputs, triggers an ADS868x conversion for each one, reads back the 16-bit result and streams it out.
// Latency: a start request shows m_axis_tvalid 1+SETTLE+2+CONV+32*SCLK_DIV+1 cycles after the cycle in which start was high.
// Backpressure: the result is held in OUT until tvalid&tready; the next channel is neither settled nor triggered before that handshake.
module ads868x_scan_ctrl #(
    parameter int SCLK_DIV      = 2,
    parameter int SETTLE_CYCLES = 64,
    parameter int CONV_CYCLES   = 100
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic        abort,
    input  logic        continuous,
    input  logic [7:0]  ch_mask,
    output logic        busy,
    output logic        done,
    output logic [2:0]  ch_sel,
    output logic        mux_en,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [15:0] m_axis_tdata,
    output logic [2:0]  m_axis_tuser,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready
);

    localparam int READ_LEN = 32 * SCLK_DIV;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUX  = 3'd1,
        TRIG = 3'd2,
        CONV = 3'd3,
        READ = 3'd4,
        OUT  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q;
    logic [2:0]  ch_d;
    logic [7:0]  mask_q;
    logic [15:0] shift_q;
    logic        done_d;
    logic [3:0]  nxt;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        lowest_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_bit = 3'(i);
        end
    endfunction

    // {found, index} of the lowest set bit strictly above cur.
    function automatic logic [3:0] next_bit(input logic [7:0] m, input logic [2:0] cur);
        next_bit = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) next_bit = {1'b1, 3'(i)};
        end
    endfunction

    assign nxt = next_bit(mask_q, ch_sel);

    // Next-state, next-channel and done-pulse decode.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_sel;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!abort && start) begin
                    if (ch_mask != 8'd0) begin
                        state_d = MUX;
                        ch_d    = lowest_bit(ch_mask);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            MUX:  if (cnt_q == 16'(SETTLE_CYCLES - 1)) state_d = TRIG;
            TRIG: if (cnt_q == 16'd1) state_d = CONV;
            CONV: if (cnt_q == 16'(CONV_CYCLES - 1)) state_d = READ;
            READ: if (cnt_q == 16'(READ_LEN - 1)) state_d = OUT;
            OUT: begin
                if (m_axis_tvalid && m_axis_tready) begin
                    if (nxt[3]) begin
                        state_d = MUX;
                        ch_d    = nxt[2:0];
                    end else if (continuous) begin
                        state_d = MUX;
                        ch_d    = lowest_bit(mask_q);
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort drops the scan silently, keeping the last channel select.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            ch_d    = ch_sel;
            done_d  = 1'b0;
        end
        cnt_d = (state_d != state_q || state_q == IDLE) ? 16'd0 : cnt_q + 16'd1;
    end

    // State, dwell counter, channel and latched mask.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            ch_sel  <= 3'd0;
            mask_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_sel  <= ch_d;
            if (state_q == IDLE && state_d == MUX) mask_q <= ch_mask;
        end
    end

    // Registered status and chip-select outputs, derived from the next state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            busy     <= 1'b0;
            mux_en   <= 1'b0;
            done     <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
        end else begin
            busy     <= (state_d != IDLE);
            mux_en   <= (state_d != IDLE);
            done     <= done_d;
            spi_cs_n <= !(state_d == TRIG || state_d == READ);
            spi_mosi <= 1'b0;
        end
    end

    // SCLK generation and MSB-first capture of MISO on each SCLK rising edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            div_q    <= 16'd0;
            spi_sclk <= 1'b0;
            shift_q  <= 16'd0;
        end else if (state_q == READ && state_d == READ) begin
            if (div_q == 16'(SCLK_DIV - 1)) begin
                div_q    <= 16'd0;
                spi_sclk <= ~spi_sclk;
                if (!spi_sclk) shift_q <= {shift_q[14:0], spi_miso};
            end else begin
                div_q <= div_q + 16'd1;
            end
        end else begin
            div_q    <= 16'd0;
            spi_sclk <= 1'b0;
        end
    end

    // Result beat: loaded one cycle after entering OUT, held until handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= 16'd0;
            m_axis_tuser  <= 3'd0;
        end else if (state_d != OUT) begin
            m_axis_tvalid <= 1'b0;
        end else if (state_q == OUT && !m_axis_tvalid) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= shift_q;
            m_axis_tuser  <= ch_sel;
        end
    end

endmodule

// File: tb/tb_ads868x_scan_ctrl.sv
// Purpose: directed self-checking bench for ads868x_scan_ctrl with a bit-serial ADC model.
// Latency: runs a fixed directed sequence of a few thousand cycles.
// Backpressure: drives m_axis_tready low for a stretch to exercise the OUT hold.
module tb_ads868x_scan_ctrl;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        continuous = 1'b0;
    logic [7:0]  ch_mask = 8'd0;
    logic        m_axis_tready = 1'b1;
    logic        busy, done, mux_en, spi_cs_n, spi_sclk, spi_mosi, spi_miso, m_axis_tvalid;
    logic [2:0]  ch_sel, m_axis_tuser;
    logic [15:0] m_axis_tdata;

    logic [15:0] adc_val [8];
    logic [3:0]  bitidx = 4'd15;
    logic        sclk_prev = 1'b0;
    logic        cs_prev = 1'b1;
    int          rises = 0;
    int          cs_falls = 0;
    int          dones = 0;
    int          beats = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 aclk = ~aclk;

    ads868x_scan_ctrl #(
        .SCLK_DIV(2),
        .SETTLE_CYCLES(4),
        .CONV_CYCLES(10)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .start(start),
        .abort(abort),
        .continuous(continuous),
        .ch_mask(ch_mask),
        .busy(busy),
        .done(done),
        .ch_sel(ch_sel),
        .mux_en(mux_en),
        .spi_cs_n(spi_cs_n),
        .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
    );

    // ADC model: MSB presented while CS is low, next bit after each SCLK fall; also event counters.
    always @(negedge aclk) begin
        if (!sclk_prev && spi_sclk) rises = rises + 1;
        if (cs_prev && !spi_cs_n) cs_falls = cs_falls + 1;
        if (done) dones = dones + 1;
        if (m_axis_tvalid && m_axis_tready) beats = beats + 1;
        if (spi_cs_n) bitidx = 4'd15;
        else if (sclk_prev && !spi_sclk && bitidx != 4'd0) bitidx = bitidx - 4'd1;
        sclk_prev = spi_sclk;
        cs_prev   = spi_cs_n;
    end

    assign spi_miso = adc_val[ch_sel][bitidx];

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_vld(input string tag, output int n);
        n = 0;
        while (!m_axis_tvalid && n < 400) begin
            tick();
            n++;
        end
        chk(tag, 32'(m_axis_tvalid), 32'd1);
    endtask

    task automatic wait_rises(input string tag, input int base, input int cnt);
        int n;
        n = 0;
        while ((rises - base) < cnt && n < 400) begin
            tick();
            n++;
        end
        chk(tag, 32'(rises - base), 32'(cnt));
    endtask

    initial begin
        int n;
        int r0, d0, b0, c0;
        logic ok;

        for (int i = 0; i < 8; i++) adc_val[i] = 16'h0000;
        adc_val[0] = 16'h1234;
        adc_val[1] = 16'h0F0F;
        adc_val[2] = 16'hA55A;
        adc_val[7] = 16'hBEEF;

        // Reset values
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ch_sel", 32'(ch_sel), 32'd0);
        chk("rst_mux_en", 32'(mux_en), 32'd0);
        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_sclk", 32'(spi_sclk), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
        chk("rst_tuser", 32'(m_axis_tuser), 32'd0);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        tick();
        aresetn = 1'b1;
        tick();
        tick();

        // Single channel 2, timing of trigger window and result latency
        ch_mask = 8'h04;
        r0 = rises;
        d0 = dones;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("one_busy", 32'(busy), 32'd1);
        chk("one_mux_en", 32'(mux_en), 32'd1);
        chk("one_ch_sel", 32'(ch_sel), 32'd2);
        chk("one_cs_c1", 32'(spi_cs_n), 32'd1);
        repeat (3) tick();
        chk("one_cs_c4", 32'(spi_cs_n), 32'd1);
        tick();
        chk("one_cs_c5", 32'(spi_cs_n), 32'd0);
        tick();
        chk("one_cs_c6", 32'(spi_cs_n), 32'd0);
        tick();
        chk("one_cs_c7", 32'(spi_cs_n), 32'd1);
        n = 7;
        while (!m_axis_tvalid && n < 300) begin
            tick();
            n++;
        end
        chk("one_latency", 32'(n), 32'd82);
        chk("one_tdata", 32'(m_axis_tdata), 32'hA55A);
        chk("one_tuser", 32'(m_axis_tuser), 32'd2);
        chk("one_sclk_rises", 32'(rises - r0), 32'd16);
        chk("one_out_cs_n", 32'(spi_cs_n), 32'd1);
        tick();
        chk("one_tvalid_clr", 32'(m_axis_tvalid), 32'd0);
        chk("one_done", 32'(done), 32'd1);
        chk("one_busy_clr", 32'(busy), 32'd0);
        chk("one_mux_en_clr", 32'(mux_en), 32'd0);
        tick();
        chk("one_done_pulse", 32'(done), 32'd0);
        chk("one_done_cnt", 32'(dones - d0), 32'd1);

        // Channels 0 and 7; mask change and start while busy are ignored
        ch_mask = 8'h81;
        r0 = rises;
        d0 = dones;
        b0 = beats;
        start = 1'b1;
        tick();
        start = 1'b0;
        ch_mask = 8'hFF;
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_vld("two_vld0", n);
        chk("two_tuser0", 32'(m_axis_tuser), 32'd0);
        chk("two_tdata0", 32'(m_axis_tdata), 32'h1234);
        tick();
        wait_vld("two_vld1", n);
        chk("two_tuser1", 32'(m_axis_tuser), 32'd7);
        chk("two_tdata1", 32'(m_axis_tdata), 32'hBEEF);
        tick();
        chk("two_done", 32'(done), 32'd1);
        chk("two_busy", 32'(busy), 32'd0);
        repeat (5) tick();
        chk("two_sclk_rises", 32'(rises - r0), 32'd32);
        chk("two_done_cnt", 32'(dones - d0), 32'd1);
        chk("two_beats", 32'(beats - b0), 32'd2);

        // Backpressure in OUT
        ch_mask = 8'h02;
        m_axis_tready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_vld("bp_vld", n);
        chk("bp_tdata", 32'(m_axis_tdata), 32'h0F0F);
        r0 = rises;
        ok = 1'b1;
        repeat (20) begin
            tick();
            if (!(m_axis_tvalid === 1'b1 && m_axis_tdata === 16'h0F0F && m_axis_tuser === 3'd1 &&
                  spi_cs_n === 1'b1 && spi_sclk === 1'b0 && ch_sel === 3'd1)) ok = 1'b0;
        end
        chk("bp_stable", 32'(ok), 32'd1);
        chk("bp_no_sclk", 32'(rises - r0), 32'd0);
        m_axis_tready = 1'b1;
        tick();
        chk("bp_tvalid_clr", 32'(m_axis_tvalid), 32'd0);
        chk("bp_done", 32'(done), 32'd1);
        tick();

        // Continuous: two full scans, clear mid third scan
        ch_mask = 8'h03;
        adc_val[1] = 16'h2222;
        adc_val[0] = 16'h1111;
        continuous = 1'b1;
        b0 = beats;
        d0 = dones;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wait_vld($sformatf("cont_vld%0d", k), n);
            chk($sformatf("cont_tuser%0d", k), 32'(m_axis_tuser), 32'(k % 2));
            chk($sformatf("cont_tdata%0d", k), 32'(m_axis_tdata), (k % 2) ? 32'h2222 : 32'h1111);
            tick();
            if (k == 3) continuous = 1'b0;
        end
        chk("cont_done", 32'(done), 32'd1);
        chk("cont_busy", 32'(busy), 32'd0);
        repeat (150) tick();
        chk("cont_beats", 32'(beats - b0), 32'd6);
        chk("cont_done_cnt", 32'(dones - d0), 32'd1);
        chk("cont_idle", 32'(busy), 32'd0);

        // Abort mid-READ after five SCLK rising edges
        ch_mask = 8'h01;
        r0 = rises;
        d0 = dones;
        b0 = beats;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_rises("abort_rises", r0, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_cs_n", 32'(spi_cs_n), 32'd1);
        chk("abort_sclk", 32'(spi_sclk), 32'd0);
        chk("abort_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_mux_en", 32'(mux_en), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (100) tick();
        chk("abort_no_beat", 32'(beats - b0), 32'd0);
        chk("abort_no_done", 32'(dones - d0), 32'd0);

        // Reset mid-READ: chip select released without waiting for a clock
        r0 = rises;
        b0 = beats;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_rises("rst_mid_rises", r0, 5);
        #2;
        aresetn = 1'b0;
        #1;
        chk("rst_mid_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_mid_sclk", 32'(spi_sclk), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_tvalid", 32'(m_axis_tvalid), 32'd0);
        tick();
        aresetn = 1'b1;
        c0 = cs_falls;
        repeat (100) tick();
        chk("rst_mid_idle", 32'(busy), 32'd0);
        chk("rst_mid_no_cs", 32'(cs_falls - c0), 32'd0);
        chk("rst_mid_no_beat", 32'(beats - b0), 32'd0);

        // Abort and start together in IDLE: abort wins
        d0 = dones;
        ch_mask = 8'h01;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abst_busy", 32'(busy), 32'd0);
        chk("abst_done", 32'(done), 32'd0);
        tick();
        chk("abst_idle", 32'(busy), 32'd0);

        // Empty mask: done pulse only
        ch_mask = 8'h00;
        c0 = cs_falls;
        d0 = dones;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_busy", 32'(busy), 32'd0);
        chk("empty_cs_n", 32'(spi_cs_n), 32'd1);
        tick();
        chk("empty_done_pulse", 32'(done), 32'd0);
        repeat (20) tick();
        chk("empty_no_cs", 32'(cs_falls - c0), 32'd0);
        chk("empty_done_cnt", 32'(dones - d0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
